pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pcpu pipeline. Arbitrates four stall sources:
//  load-use hazard (from hazard detection), EX branch/jump redirect, multi-cycle MUL/DIV in EX,
//  and data-memory wait in MEM. Drives every pipeline-register write enable and flush.
//  Counts stall cycles for performance monitoring.
// PARAMETERS
//  MUL_CYCLES  3   MDU multiply latency in cycles (>=1)
//  DIV_CYCLES  33  MDU divide latency in cycles (>=1)
//  CNT_W       6   latency counter width; must hold DIV_CYCLES-1
// PORTS
//  clk             in   1   single clock, rising edge
//  rst             in   1   synchronous, active-high reset
//  lu_hazard       in   1   load-use hazard, from hazard detection (EX load rd == ID rs1/rs2)
//  ex_branch_taken in   1   EX resolved taken branch/jump; PC redirect this cycle
//  ex_mdu_start    in   1   EX holds a MUL/DIV op not yet started
//  ex_mdu_is_div   in   1   1 = divide latency, 0 = multiply latency
//  mem_req         in   1   MEM stage load/store active
//  mem_ready       in   1   data memory completes access this cycle
//  pc_write        out  1   PC register enable
//  if_id_write     out  1   IF/ID enable
//  id_ex_write     out  1   ID/EX enable
//  ex_mem_write    out  1   EX/MEM enable
//  mem_wb_write    out  1   MEM/WB enable
//  if_id_flush     out  1   IF/ID load bubble
//  id_ex_flush     out  1   ID/EX load bubble
//  ex_mem_flush    out  1   EX/MEM load bubble
//  mdu_go          out  1   one-cycle MDU start pulse
//  ctrl_state      out  2   current FSM state (debug)
//  stall_cnt       out  32  cycles with pc_write==0, wraps at 2^32
// BEHAVIOUR
//  - States: RUN=0, MDU_WAIT=1, MEM_WAIT=2. Registered: state, lat_cnt, stall_cnt. Other outputs combinational.
//  - While rst=1: all *_write=0, all flushes=1, mdu_go=0. Next cycle: state=RUN, lat_cnt=0, stall_cnt=0.
//  - Default (no event): all writes=1, flushes=0, mdu_go=0.
//  - mem_freeze = mem_req && !mem_ready, in any state. Highest priority.
//    Effect: all five write enables=0, no flushes, mdu_go=0.
//  - RUN transitions/outputs, priority top-down:
//    mem_freeze -> state MEM_WAIT.
//    ex_mdu_start -> mdu_go=1; lat_cnt<=(is_div?DIV_CYCLES:MUL_CYCLES)-1; state MDU_WAIT;
//      pc/if_id/id_ex write=0, ex_mem_flush=1 (bubble to MEM), mem_wb advances.
//    ex_branch_taken -> pc_write=1 (redirect), if_id_flush=1, id_ex_flush=1.
//      Overrides lu_hazard (stalled ID instr is squashed anyway).
//    lu_hazard -> pc_write=0, if_id_write=0, id_ex_flush=1 (one bubble; no state change).
//  - MDU_WAIT: lat_cnt decrements to 0 and holds, independent of mem_freeze.
//    lat_cnt!=0: outputs as MDU entry, mdu_go=0.
//    lat_cnt==0 and !mem_freeze: all writes=1, result captured into EX/MEM, state RUN.
//    lat_cnt==0 and mem_freeze: full freeze, remain MDU_WAIT.
//    ex_mdu_start/branch/lu ignored in this state.
//  - MEM_WAIT: full freeze while mem_freeze.
//    On mem_ready=1: writes released that same cycle, state RUN.
//    RUN-priority events are evaluated in that release cycle.
//  - ex_mdu_start && ex_branch_taken together is illegal (same EX instr); MDU wins, bench asserts.
//  - stall_cnt increments every non-reset cycle with pc_write==0.
//  - Reset mid-MDU_WAIT/MEM_WAIT: abandons op; mdu_go not reissued; MDU itself reset by rst.
// STRUCTURE
//  - pcpu_ctrl_pkg: state encodings RUN/MDU_WAIT/MEM_WAIT, latency constants, stall-source enum.
//  - One sub-module: mdu_latency_counter (load, decrement, zero flag; CNT_W wide).
//  - FSM plus output decode stay in this module.
// TESTING
//  1. lu_hazard=1 for 1 cycle in RUN -> pc_write=0, if_id_write=0, id_ex_flush=1 that cycle only; stall_cnt+1.
//  2. ex_branch_taken=1 with lu_hazard=1 -> pc_write=1, if_id_flush=1, id_ex_flush=1.
//  3. ex_mdu_start=1, ex_mdu_is_div=0 -> mdu_go 1 cycle; pc_write=0 for 3 cycles, released on 3rd (lat_cnt==0); state back RUN.
//  4. DIV start, mem_req=1/mem_ready=0 held over lat_cnt==0 -> stays MDU_WAIT, full freeze; release cycle after mem_ready=1.
//  5. mem_req=1, mem_ready=0 for 4 cycles -> all writes 0 for 4 cycles, state MEM_WAIT; writes=1 on mem_ready cycle.
//  6. rst=1 mid-DIV (lat_cnt=20) -> next cycle state=RUN, lat_cnt=0, stall_cnt=0, mdu_go=0.

Source files
------------

// File: rtl/pcpu_ctrl_pkg.sv
// pcpu_ctrl_pkg
//   Shared types and defaults for the pcpu pipeline stall/flush sequencer.
//   - ctrl_state_e : sequencer FSM encoding (RUN / MDU_WAIT / MEM_WAIT)
//   - stall_src_e  : the event that decides this cycle's enables and flushes
//   - default MDU latencies and the latency counter width
package pcpu_ctrl_pkg;

  localparam int unsigned MUL_CYCLES_DEF = 3;
  localparam int unsigned DIV_CYCLES_DEF = 33;
  localparam int unsigned CNT_W_DEF      = 6;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_e;

  // MDU_START is the issue cycle (pulses mdu_go); MDU_BUSY covers the
  // remaining cycles until the result is ready.
  typedef enum logic [2:0] {
    SRC_NONE      = 3'd0,
    SRC_MEM       = 3'd1,
    SRC_MDU_START = 3'd2,
    SRC_MDU_BUSY  = 3'd3,
    SRC_BRANCH    = 3'd4,
    SRC_LU        = 3'd5
  } stall_src_e;

endpackage

// File: rtl/mdu_latency_counter.sv
// mdu_latency_counter
//   Down-counter that tracks the cycles remaining on a MUL/DIV operation.
//   Load takes priority over decrement; the count saturates at zero.
// Ports
//   clk_i      in   clock, rising edge
//   rst_i      in   synchronous active-high reset (count -> 0)
//   load_i     in   load load_val_i this cycle
//   load_val_i in   CNT_W  value to load
//   dec_i      in   decrement by one (held at zero once reached)
//   cnt_o      out  CNT_W  current count
//   zero_o     out  count is zero
module mdu_latency_counter #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//   Stall/flush sequencer for the 5-stage pcpu pipeline. Arbitrates
//   data-memory wait, multi-cycle MUL/DIV, taken branch and load-use hazard,
//   drives all pipeline-register enables/flushes and counts stall cycles.
// Ports
//   clk, rst                      clock / synchronous active-high reset
//   lu_hazard                     load-use hazard from hazard detection
//   ex_branch_taken               EX taken branch/jump (PC redirect)
//   ex_mdu_start, ex_mdu_is_div   EX holds an unstarted MUL/DIV, and its kind
//   mem_req, mem_ready            MEM access active / completing this cycle
//   pc_write .. mem_wb_write      pipeline register enables
//   if_id/id_ex/ex_mem_flush      load a bubble into the register
//   mdu_go                        one-cycle MDU start pulse
//   ctrl_state                    FSM state (debug)
//   stall_cnt                     cycles with pc_write==0, wraps
//
// state    | meaning
// RUN      | normal flow; RUN-priority events decoded
// MDU_WAIT | MUL/DIV in flight; front end held, bubbles into MEM
// MEM_WAIT | data memory busy; whole pipe frozen
module pipeline_stall_ctrl
  import pcpu_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lu_hazard,
  input  logic        ex_branch_taken,
  input  logic        ex_mdu_start,
  input  logic        ex_mdu_is_div,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        ex_mem_write,
  output logic        mem_wb_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mdu_go,
  output logic [1:0]  ctrl_state,
  output logic [31:0] stall_cnt
);

  ctrl_state_e      state_q, state_d;
  stall_src_e       src;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             mem_freeze;
  logic             lat_load;
  logic [CNT_W-1:0] lat_load_val;
  logic [CNT_W-1:0] lat_cnt;
  logic             lat_zero;

  assign mem_freeze   = mem_req && !mem_ready;
  assign lat_load_val = ex_mdu_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);

  mdu_latency_counter #(.CNT_W(CNT_W)) u_lat_cnt (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (lat_load),
    .load_val_i (lat_load_val),
    .dec_i      (state_q == MDU_WAIT),
    .cnt_o      (lat_cnt),
    .zero_o     (lat_zero)
  );

  // Next state and stall source. MEM_WAIT shares RUN's decode: once the
  // freeze drops, the release cycle evaluates RUN events directly.
  always_comb begin
    state_d  = state_q;
    src      = SRC_NONE;
    lat_load = 1'b0;
    case (state_q)
      MDU_WAIT: begin
        if (mem_freeze) begin
          src = SRC_MEM;
        end else if (!lat_zero) begin
          src = SRC_MDU_BUSY;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        if (mem_freeze) begin
          src     = SRC_MEM;
          state_d = MEM_WAIT;
        end else if (ex_mdu_start) begin
          src      = SRC_MDU_START;
          lat_load = 1'b1;
          state_d  = MDU_WAIT;
        end else begin
          state_d = RUN;
          if (ex_branch_taken) begin
            src = SRC_BRANCH;
          end else if (lu_hazard) begin
            src = SRC_LU;
          end
        end
      end
    endcase
    if (rst) begin
      lat_load = 1'b0;
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mdu_go       = 1'b0;
    case (src)
      SRC_MEM: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_write = 1'b0;
      end
      SRC_MDU_START, SRC_MDU_BUSY: begin
        mdu_go       = (src == SRC_MDU_START);
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_flush = 1'b1;
      end
      SRC_BRANCH: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      SRC_LU: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mdu_go       = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ctrl_state = state_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed-vector bench for pipeline_stall_ctrl (MUL=3, DIV=33).
// Inputs are driven on the falling edge and outputs checked 1 ns later.
// Input key:  {rst, lu, br, mdu_start, is_div, mem_req, mem_ready}
// Write key:  {pc, if_id, id_ex, ex_mem, mem_wb}
// Flush key:  {if_id, id_ex, ex_mem}
module tb_pipeline_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst, lu_hazard, ex_branch_taken, ex_mdu_start, ex_mdu_is_div;
  logic        mem_req, mem_ready;
  logic        pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mdu_go;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .lu_hazard       (lu_hazard),
    .ex_branch_taken (ex_branch_taken),
    .ex_mdu_start    (ex_mdu_start),
    .ex_mdu_is_div   (ex_mdu_is_div),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .ex_mem_write    (ex_mem_write),
    .mem_wb_write    (mem_wb_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_flush    (ex_mem_flush),
    .mdu_go          (mdu_go),
    .ctrl_state      (ctrl_state),
    .stall_cnt       (stall_cnt)
  );

  always @(posedge clk) begin
    assert (!(ex_mdu_start && ex_branch_taken))
      else $error("illegal stimulus: mdu_start with branch_taken");
  end

  typedef struct {
    string       tag;
    logic [6:0]  in;
    logic [4:0]  wr;
    logic [2:0]  fl;
    logic        go;
    logic [1:0]  st;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string tag, logic [6:0] in, logic [4:0] wr,
                              logic [2:0] fl, logic go, logic [1:0] st,
                              logic [31:0] cnt);
    vec_t v;
    v.tag = tag; v.in = in; v.wr = wr; v.fl = fl; v.go = go; v.st = st; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(string tag, logic [6:0] in, logic [4:0] wr, logic [2:0] fl,
                     logic go, logic [1:0] st, logic [31:0] cnt);
    @(negedge clk);
    {rst, lu_hazard, ex_branch_taken, ex_mdu_start, ex_mdu_is_div, mem_req, mem_ready} = in;
    #1;
    chk({tag, ".wr"}, 32'({pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write}), 32'(wr));
    chk({tag, ".fl"}, 32'({if_id_flush, id_ex_flush, ex_mem_flush}), 32'(fl));
    chk({tag, ".go"}, 32'(mdu_go), 32'(go));
    chk({tag, ".st"}, 32'(ctrl_state), 32'(st));
    chk({tag, ".cnt"}, stall_cnt, cnt);
  endtask

  initial begin
    {rst, lu_hazard, ex_branch_taken, ex_mdu_start, ex_mdu_is_div, mem_req, mem_ready} = 7'b1000000;
    repeat (2) @(posedge clk);

    //             tag            rst/lu/br/mdu/div/req/rdy  wr        fl      go  st  cnt
    tbl.push_back(mk("reset",       7'b1000000, 5'b00000, 3'b111, 0, 0, 0));
    tbl.push_back(mk("idle",        7'b0000000, 5'b11111, 3'b000, 0, 0, 0));
    tbl.push_back(mk("lu",          7'b0100000, 5'b00111, 3'b010, 0, 0, 0));
    tbl.push_back(mk("lu_after",    7'b0000000, 5'b11111, 3'b000, 0, 0, 1));
    tbl.push_back(mk("br_lu",       7'b0110000, 5'b11111, 3'b110, 0, 0, 1));
    tbl.push_back(mk("br",          7'b0010000, 5'b11111, 3'b110, 0, 0, 1));
    tbl.push_back(mk("mul_go",      7'b0001000, 5'b00011, 3'b001, 1, 0, 1));
    tbl.push_back(mk("mul_w2",      7'b0001000, 5'b00011, 3'b001, 0, 1, 2));
    tbl.push_back(mk("mul_w1",      7'b0100000, 5'b00011, 3'b001, 0, 1, 3));
    tbl.push_back(mk("mul_rel",     7'b0000000, 5'b11111, 3'b000, 0, 1, 4));
    tbl.push_back(mk("mul_done",    7'b0000000, 5'b11111, 3'b000, 0, 0, 4));
    tbl.push_back(mk("mem_f1",      7'b0000010, 5'b00000, 3'b000, 0, 0, 4));
    tbl.push_back(mk("mem_f2",      7'b0000010, 5'b00000, 3'b000, 0, 2, 5));
    tbl.push_back(mk("mem_f3",      7'b0000010, 5'b00000, 3'b000, 0, 2, 6));
    tbl.push_back(mk("mem_f4",      7'b0000010, 5'b00000, 3'b000, 0, 2, 7));
    tbl.push_back(mk("mem_rel",     7'b0000011, 5'b11111, 3'b000, 0, 2, 8));
    tbl.push_back(mk("mem_done",    7'b0000000, 5'b11111, 3'b000, 0, 0, 8));
    tbl.push_back(mk("mem2_f",      7'b0000010, 5'b00000, 3'b000, 0, 0, 8));
    tbl.push_back(mk("mem2_rel_lu", 7'b0100011, 5'b00111, 3'b010, 0, 2, 9));
    tbl.push_back(mk("mem3_f",      7'b0000010, 5'b00000, 3'b000, 0, 0, 10));
    tbl.push_back(mk("mem3_rel_mul",7'b0001011, 5'b00011, 3'b001, 1, 2, 11));
    tbl.push_back(mk("mul_frz",     7'b0000010, 5'b00000, 3'b000, 0, 1, 12));
    tbl.push_back(mk("mul_w1b",     7'b0000000, 5'b00011, 3'b001, 0, 1, 13));
    tbl.push_back(mk("mul_relb",    7'b0000000, 5'b11111, 3'b000, 0, 1, 14));
    tbl.push_back(mk("mdu_vs_mem",  7'b0001010, 5'b00000, 3'b000, 0, 0, 14));
    tbl.push_back(mk("memdrop_br",  7'b0010000, 5'b11111, 3'b110, 0, 2, 15));
    tbl.push_back(mk("idle2",       7'b0000000, 5'b11111, 3'b000, 0, 0, 15));
    tbl.push_back(mk("mem_hit",     7'b0000011, 5'b11111, 3'b000, 0, 0, 15));

    foreach (tbl[i]) begin
      cyc(tbl[i].tag, tbl[i].in, tbl[i].wr, tbl[i].fl, tbl[i].go, tbl[i].st, tbl[i].cnt);
    end

    // DIV with a memory freeze spanning the last count and lat_cnt==0.
    cyc("div_go", 7'b0001100, 5'b00011, 3'b001, 1, 0, 15);
    for (int i = 0; i < 30; i++)
      cyc("div_busy", 7'b0000000, 5'b00011, 3'b001, 0, 1, 32'(16 + i));
    for (int i = 0; i < 2; i++)
      cyc("div_frz_dec", 7'b0000010, 5'b00000, 3'b000, 0, 1, 32'(46 + i));
    for (int i = 0; i < 2; i++)
      cyc("div_frz_zero", 7'b0000010, 5'b00000, 3'b000, 0, 1, 32'(48 + i));
    cyc("div_release", 7'b0000011, 5'b11111, 3'b000, 0, 1, 50);
    cyc("div_done",    7'b0000000, 5'b11111, 3'b000, 0, 0, 50);

    // Reset in the middle of a DIV (lat_cnt at 20).
    cyc("div2_go", 7'b0001100, 5'b00011, 3'b001, 1, 0, 50);
    for (int i = 0; i < 12; i++)
      cyc("div2_busy", 7'b0000000, 5'b00011, 3'b001, 0, 1, 32'(51 + i));
    cyc("rst_mid_div",  7'b1000000, 5'b00000, 3'b111, 0, 1, 63);
    cyc("post_rst",     7'b0000000, 5'b11111, 3'b000, 0, 0, 0);
    cyc("post_rst_idle",7'b0000000, 5'b11111, 3'b000, 0, 0, 0);
    // A fresh MUL after reset must take its full latency.
    cyc("mul3_go",  7'b0001000, 5'b00011, 3'b001, 1, 0, 0);
    cyc("mul3_w2",  7'b0000000, 5'b00011, 3'b001, 0, 1, 1);
    cyc("mul3_w1",  7'b0000000, 5'b00011, 3'b001, 0, 1, 2);
    cyc("mul3_rel", 7'b0000000, 5'b11111, 3'b000, 0, 1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
